// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
// Module : operand_stage
// ID->EX operand stage: operand bypass network, load-use interlock, ID/EX reg.
// Rev    : 1.0  initial release
// ============================================================================
module operand_stage #(
   parameter int XLEN  = 32,
   parameter int PAY_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [1:0]       id_use,
   input  logic [4:0]       id_rd,
   input  logic             id_rd_we,
   input  logic             id_is_load,
   input  logic [PAY_W-1:0] id_payload,
   output logic [4:0]       rf_ad1,
   output logic [4:0]       rf_ad2,
   input  logic [XLEN-1:0]  rf_rd1,
   input  logic [XLEN-1:0]  rf_rd2,
   input  logic [XLEN-1:0]  ex_fwd_result,
   input  logic [4:0]       mem_rd,
   input  logic             mem_we,
   input  logic             mem_is_load,
   input  logic [XLEN-1:0]  mem_result,
   input  logic [4:0]       wb_rd,
   input  logic             wb_we,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             ex_ready,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_op_a,
   output logic [XLEN-1:0]  ex_op_b,
   output logic [4:0]       ex_rd,
   output logic             ex_rd_we,
   output logic             ex_is_load,
   output logic [PAY_W-1:0] ex_payload
);

   logic [1:0][4:0]      w_rs;
   logic [1:0][XLEN-1:0] w_rf;
   logic [XLEN-1:0]      w_op_a;
   logic [XLEN-1:0]      w_op_b;
   logic                 w_hazard;
   logic                 w_advance;

   assign rf_ad1 = id_rs1;
   assign rf_ad2 = id_rs2;
   assign w_rs   = {id_rs2, id_rs1};
   assign w_rf   = {rf_rd2, rf_rd1};

   for (genvar s = 0; s < 2; s++) begin : g_src
      logic            w_live;
      logic            w_ex_hit;
      logic            w_mem_hit;
      logic            w_wb_hit;
      logic            w_hz;
      logic [XLEN-1:0] w_sel;

      assign w_live    = id_use[s] && (w_rs[s] != 5'd0);
      assign w_ex_hit  = ex_valid && ex_rd_we && (ex_rd == w_rs[s]);
      assign w_mem_hit = mem_we && (mem_rd == w_rs[s]);
      assign w_wb_hit  = wb_we && (wb_rd == w_rs[s]);
      // A load ahead in EX or MEM has no data yet: stall rather than bypass.
      assign w_hz      = w_live && ((w_ex_hit && ex_is_load) || (w_mem_hit && mem_is_load));

      always_comb begin
         w_sel = w_rf[s];
         if (id_use[s]) begin
            if (w_rs[s] == 5'd0)               w_sel = '0;
            else if (w_ex_hit && !ex_is_load)  w_sel = ex_fwd_result;
            else if (w_mem_hit && !mem_is_load) w_sel = mem_result;
            else if (w_wb_hit)                 w_sel = wb_data;
         end
      end
   end

   assign w_op_a    = g_src[0].w_sel;
   assign w_op_b    = g_src[1].w_sel;
   assign w_hazard  = g_src[0].w_hz || g_src[1].w_hz;
   assign w_advance = ex_ready || !ex_valid;
   assign id_ready  = w_advance && !w_hazard;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid   <= 1'b0;
         ex_op_a    <= '0;
         ex_op_b    <= '0;
         ex_rd      <= '0;
         ex_rd_we   <= 1'b0;
         ex_is_load <= 1'b0;
         ex_payload <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (w_advance) begin
         if (id_valid && id_ready) begin
            ex_valid   <= 1'b1;
            ex_op_a    <= w_op_a;
            ex_op_b    <= w_op_b;
            ex_rd      <= id_rd;
            ex_rd_we   <= id_rd_we;
            ex_is_load <= id_is_load;
            ex_payload <= id_payload;
         end else begin
            // Bubble: only the valid bit drops, the stale fields stay put.
            ex_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
